// File: rtl/ama_riscv_defines.sv
// ama_riscv_defines: shared front-end types, plus gshare predictor constants and checkpoint layout.
package ama_riscv_defines;

    typedef logic [31:0] arch_width_t;

    typedef enum logic [1:0] {
        B_NT = 2'b00,
        B_T  = 2'b01
    } branch_t;

    typedef struct packed {
        logic enter;
        logic resolve;
        logic wrong;
    } spec_exec_t;

    localparam logic [1:0] BP_CNT_WNT = 2'b01;
    localparam int BP_PHT_IDX_W = 8;
    localparam int BP_GHR_W = 8;

    typedef struct packed {
        logic [BP_PHT_IDX_W-1:0] idx;
        logic [BP_GHR_W-1:0]     ghr;
        branch_t                 pred;
    } bp_ckpt_t;

endpackage

// File: rtl/ama_riscv_bp_gshare_pht.sv
// ama_riscv_bp_pht: pattern history table of 2-bit saturating counters,
// one async read port and one clocked saturating-update port.
module ama_riscv_bp_pht
    import ama_riscv_defines::*;
#(
    parameter int IDX_W = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam int N = 1 << IDX_W;

    logic [1:0] cnt [N];
    logic [1:0] cur;
    logic [1:0] upd;

    // no write-to-read bypass: a same-cycle lookup sees the old counter
    assign rd_cnt = cnt[rd_idx];
    assign cur = cnt[wr_idx];
    assign upd = wr_taken ? ((cur == 2'b11) ? cur : cur + 2'b01)
                          : ((cur == 2'b00) ? cur : cur - 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cnt[i] <= BP_CNT_WNT;
        end else if (we) begin
            cnt[wr_idx] <= upd;
        end
    end

endmodule

// File: rtl/ama_riscv_bp_gshare.sv
// ama_riscv_bp_gshare: gshare predictor with speculative global history and a single checkpoint.
// Define BP_STATS_EN to add free-running prediction/miss counters.
module ama_riscv_bp_gshare
    import ama_riscv_defines::*;
#(
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  arch_width_t pc_dec,
    input  logic [31:0] inst_dec,
    input  logic        branch_inst_dec,
    input  spec_exec_t  spec,
    input  branch_t     branch_resolution,
    output branch_t     bp_pred,
    output arch_width_t bp_target
`ifdef BP_STATS_EN
    ,
    output logic [31:0] bp_stat_pred,
    output logic [31:0] bp_stat_miss
`endif
);
    if (GHR_W < 1 || GHR_W > PHT_IDX_W || PHT_IDX_W > BP_PHT_IDX_W) begin : g_bad_cfg
        $error("ama_riscv_bp_gshare: need 1 <= GHR_W <= PHT_IDX_W <= %0d", BP_PHT_IDX_W);
    end

    typedef enum logic {IDLE, SPEC} bp_state_t;

    bp_state_t            state, state_nxt;
    logic [GHR_W-1:0]     ghr, ghr_nxt;
    bp_ckpt_t             ckpt;
    logic [PHT_IDX_W-1:0] idx;
    logic [1:0]           cnt;
    logic                 ckpt_vld;
    logic                 accept;
    logic                 res_vld;
    logic                 wrong_vld;
    logic                 taken_act;
    logic                 unused_ok;

    assign idx = pc_dec[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign bp_pred = (branch_inst_dec && cnt[1]) ? B_T : B_NT;
    assign bp_target = pc_dec + {{19{inst_dec[31]}}, inst_dec[31], inst_dec[7],
                                 inst_dec[30:25], inst_dec[11:8], 1'b0};

    assign ckpt_vld = state == SPEC;
    // a held enter while a checkpoint is live is a stall, not a new branch
    assign accept = spec.enter && (!ckpt_vld || spec.resolve) && !spec.wrong;
    assign res_vld = spec.resolve && ckpt_vld;
    assign wrong_vld = res_vld && spec.wrong;
    assign taken_act = branch_resolution == B_T;

    always_comb begin
        state_nxt = accept ? SPEC : (res_vld ? IDLE : state);
        ghr_nxt = wrong_vld ? GHR_W'({ckpt.ghr, taken_act})
                : (accept ? GHR_W'({ghr, bp_pred == B_T}) : ghr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ghr <= '0;
            ckpt <= '0;
        end else begin
            state <= state_nxt;
            ghr <= ghr_nxt;
            if (accept) ckpt <= '{idx: BP_PHT_IDX_W'(idx), ghr: BP_GHR_W'(ghr), pred: bp_pred};
        end
    end

    ama_riscv_bp_pht #(.IDX_W(PHT_IDX_W)) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_cnt   (cnt),
        .we       (res_vld),
        .wr_idx   (PHT_IDX_W'(ckpt.idx)),
        .wr_taken (taken_act)
    );

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_stat_pred <= '0;
            bp_stat_miss <= '0;
        end else begin
            if (accept) bp_stat_pred <= bp_stat_pred + 32'd1;
            if (wrong_vld) bp_stat_miss <= bp_stat_miss + 32'd1;
        end
    end
`endif

    assign unused_ok = ^{pc_dec[31:PHT_IDX_W+2], pc_dec[1:0], inst_dec[24:12],
                         inst_dec[6:0], ckpt.pred};

endmodule

// File: tb/tb_ama_riscv_bp_gshare.sv
// tb_ama_riscv_bp_gshare: scoreboard bench for the gshare predictor against a behavioural model.
module tb_ama_riscv_bp_gshare;
    import ama_riscv_defines::*;

    localparam logic [31:0] BEQ_M8 = 32'hFE000CE3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    arch_width_t pc_dec = '0;
    logic [31:0] inst_dec = '0;
    logic        branch_inst_dec = 1'b0;
    spec_exec_t  spec = '0;
    branch_t     branch_resolution = B_NT;
    branch_t     bp_pred;
    arch_width_t bp_target;
`ifdef BP_STATS_EN
    logic [31:0] bp_stat_pred;
    logic [31:0] bp_stat_miss;
`endif

    ama_riscv_bp_gshare dut (
        .clk               (clk),
        .rst               (rst),
        .pc_dec            (pc_dec),
        .inst_dec          (inst_dec),
        .branch_inst_dec   (branch_inst_dec),
        .spec              (spec),
        .branch_resolution (branch_resolution),
        .bp_pred           (bp_pred),
        .bp_target         (bp_target)
`ifdef BP_STATS_EN
        ,
        .bp_stat_pred      (bp_stat_pred),
        .bp_stat_miss      (bp_stat_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  pred;
        logic [31:0] target;
        logic [7:0]  ghr;
        logic        vld;
        logic [7:0]  cidx;
        logic [1:0]  cnt;
        logic [31:0] sp;
        logic [31:0] sm;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  m_pht [256];
    logic [7:0]  m_ghr, m_cidx, m_cghr;
    logic        m_vld;
    logic [31:0] m_sp, m_sm;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
        m_ghr = '0;
        m_cidx = '0;
        m_cghr = '0;
        m_vld = 1'b0;
        m_sp = '0;
        m_sm = '0;
    endtask

    // drive one cycle at negedge, push the model's view, then advance the model past the next posedge
    task automatic cyc(input logic r, input logic [31:0] pc, input logic [31:0] inst, input logic bi,
                       input logic en, input logic res, input logic wr, input branch_t act);
        exp_t e;
        logic [7:0] i;
        logic p, acc, rv;
        logic [12:0] imm;
        @(negedge clk);
        rst = r;
        pc_dec = pc;
        inst_dec = inst;
        branch_inst_dec = bi;
        spec = '{enter: en, resolve: res, wrong: wr};
        branch_resolution = act;
        if (r) m_reset();
        #1;
        i = pc[9:2] ^ m_ghr;
        p = bi && m_pht[i][1];
        imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        e.pred = p ? B_T : B_NT;
        e.target = pc + 32'($signed(imm));
        e.ghr = m_ghr;
        e.vld = m_vld;
        e.cidx = m_cidx;
        e.cnt = m_pht[m_cidx];
        e.sp = m_sp;
        e.sm = m_sm;
        sb.push_back(e);
        if (!r) begin
            acc = en && (!m_vld || res) && !wr;
            rv = res && m_vld;
            if (rv) m_pht[m_cidx] = (act == B_T) ? ((m_pht[m_cidx] == 2'd3) ? 2'd3 : 2'(m_pht[m_cidx] + 2'd1))
                                                 : ((m_pht[m_cidx] == 2'd0) ? 2'd0 : 2'(m_pht[m_cidx] - 2'd1));
            if (rv && wr) begin
                m_ghr = {m_cghr[6:0], act == B_T};
                m_sm++;
            end else if (acc) begin
                m_cidx = i;
                m_cghr = m_ghr;
                m_ghr = {m_ghr[6:0], p};
            end
            if (acc) m_sp++;
            m_vld = acc ? 1'b1 : (rv ? 1'b0 : m_vld);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pred", 32'(bp_pred), 32'(e.pred));
            check("target", bp_target, e.target);
            check("ghr", 32'(dut.ghr), 32'(e.ghr));
            check("ckpt_vld", 32'(dut.ckpt_vld), 32'(e.vld));
            check("ckpt_cnt", 32'(dut.u_pht.cnt[e.cidx]), 32'(e.cnt));
`ifdef BP_STATS_EN
            check("stat_pred", bp_stat_pred, e.sp);
            check("stat_miss", bp_stat_miss, e.sm);
`endif
        end
    end

    initial begin
        int bad;
        m_reset();
        cyc(1, 32'h100, BEQ_M8, 1, 0, 0, 0, B_NT);
        cyc(1, 32'h100, BEQ_M8, 1, 0, 0, 0, B_NT);
        // reset lookup of beq -8 at 0x100
        cyc(0, 32'h100, BEQ_M8, 1, 0, 0, 0, B_NT);
        #1 check("t1_pred", 32'(bp_pred), 32'(B_NT));
        check("t1_target", bp_target, 32'hF8);
        // train idx 0x40 twice with ghr held at 0
        cyc(0, 32'h100, BEQ_M8, 1, 1, 0, 0, B_NT);
        cyc(0, 32'h100, BEQ_M8, 1, 0, 1, 0, B_T);
        cyc(0, 32'h100, BEQ_M8, 0, 1, 0, 0, B_NT);
        cyc(0, 32'h100, BEQ_M8, 0, 0, 1, 0, B_T);
        cyc(0, 32'h100, BEQ_M8, 1, 0, 0, 0, B_NT);
        #1 check("t2_pred", 32'(bp_pred), 32'(B_T));
        check("t2_cnt", 32'(dut.u_pht.cnt[8'h40]), 32'd3);
        // saturation at 3, then at 0
        cyc(0, 32'h100, BEQ_M8, 1, 1, 0, 0, B_NT);
        cyc(0, 32'h100, BEQ_M8, 1, 0, 1, 0, B_T);
        cyc(0, 32'h300, BEQ_M8, 0, 0, 0, 0, B_NT);
        #1 check("t3_sat_hi", 32'(dut.u_pht.cnt[8'h40]), 32'd3);
        check("t3_ghr", 32'(dut.ghr), 32'h01);
        cyc(0, 32'h300, BEQ_M8, 0, 1, 0, 0, B_NT);
        cyc(0, 32'h300, BEQ_M8, 0, 0, 1, 0, B_NT);
        cyc(0, 32'h30C, BEQ_M8, 0, 1, 0, 0, B_NT);
        cyc(0, 32'h30C, BEQ_M8, 0, 0, 1, 0, B_NT);
        cyc(0, 32'h110, BEQ_M8, 0, 0, 0, 0, B_NT);
        #1 check("t3_sat_lo", 32'(dut.u_pht.cnt[8'hC1]), 32'd0);
        // predict T with ghr 0x04, then mispredict with a same-cycle enter
        cyc(0, 32'h110, BEQ_M8, 1, 1, 0, 0, B_NT);
        #1 check("t4_pred", 32'(bp_pred), 32'(B_T));
        cyc(0, 32'h100, BEQ_M8, 1, 1, 1, 1, B_NT);
        #1 check("t4_spec_ghr", 32'(dut.ghr), 32'h09);
        cyc(0, 32'h100, BEQ_M8, 0, 0, 0, 0, B_NT);
        #1 check("t4_fix_ghr", 32'(dut.ghr), 32'h08);
        check("t4_vld", 32'(dut.ckpt_vld), 32'd0);
        // correct resolve with a new enter at 0x200
        cyc(0, 32'h100, BEQ_M8, 1, 1, 0, 0, B_NT);
        cyc(0, 32'h200, BEQ_M8, 1, 1, 1, 0, B_NT);
        cyc(0, 32'h200, BEQ_M8, 0, 0, 0, 0, B_NT);
        #1 check("t5_vld", 32'(dut.ckpt_vld), 32'd1);
        check("t5_idx", 32'(dut.ckpt.idx), 32'h90);
        check("t5_old_cnt", 32'(dut.u_pht.cnt[8'h48]), 32'd0);
        // reset while a checkpoint is live
        cyc(1, 32'h200, BEQ_M8, 1, 0, 0, 0, B_NT);
        #1 bad = 0;
        for (int i = 0; i < 256; i++) if (dut.u_pht.cnt[i] !== 2'b01) bad++;
        check("t6_pht", 32'(bad), 32'd0);
        check("t6_ghr", 32'(dut.ghr), 32'd0);
        check("t6_vld", 32'(dut.ckpt_vld), 32'd0);
`ifdef BP_STATS_EN
        check("t6_stats", bp_stat_pred | bp_stat_miss, 32'd0);
`endif
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? {$urandom(), 2'b00} : 32'(32'h100 << $urandom_range(0, 2));
            cyc($urandom_range(0, 79) == 0, pc, $urandom(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) ? B_T : B_NT);
        end
        cyc(0, 32'h100, BEQ_M8, 0, 0, 0, 0, B_NT);
        @(negedge clk);
        #3 check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
